// File: rtl/game_ctrl.sv
// Game sequencer for the factorization game: start request, question-number
// handshake, answer countdown, judging, and the 4-bit STATE code for display.
module game_ctrl #(
  parameter int SEC_CYCLES = 50_000_000,
  parameter int ANSWER_SEC = 9,
  parameter int RESULT_SEC = 3,
  parameter int ROUNDS     = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_1P,
  input  logic       OK,
  input  logic [3:0] NUM,
  input  logic       ANS_VALID,
  input  logic       ANS_CORRECT,
  output logic [3:0] STATE,
  output logic       READY_1P,
  output logic [3:0] Q_NUM,
  output logic [3:0] TIME_LEFT,
  output logic [3:0] SCORE,
  output logic [3:0] MISS,
  output logic [3:0] ROUND
);

  // Handshake: READY_1P is a one-cycle request; the ready stage answers with
  // OK (a level), and NUM is taken on the first OK cycle seen in WAIT_OK only.

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ARM     = 4'd1,
    S_WAIT_OK = 4'd2,
    S_ANSWER  = 4'd4,
    S_DRAW    = 4'd6,
    S_GOOD    = 4'd8,
    S_OUCH    = 4'd9,
    S_WIN     = 4'd10,
    S_LOSE    = 4'd11
  } state_e;

  localparam int          TW          = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SEC_CYCLES - 1);
  localparam logic [3:0]  ANSWER_SEC_4 = 4'(ANSWER_SEC);
  localparam logic [3:0]  RESULT_LAST  = 4'(RESULT_SEC - 1);
  localparam logic [3:0]  ROUNDS_4     = 4'(ROUNDS);

  state_e        state_q, state_d;
  logic          ready_q, ready_d;
  logic [3:0]    q_num_q, q_num_d;
  logic [3:0]    time_left_q, time_left_d;
  logic [3:0]    score_q, score_d;
  logic [3:0]    miss_q, miss_d;
  logic [3:0]    round_q, round_d;
  logic [3:0]    sec_q, sec_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          btn_q;

  logic       btn_rise;
  logic       tick;
  logic [3:0] round_next;

  assign btn_rise   = BTN_1P & ~btn_q;
  assign tick       = (tick_cnt_q == TICK_LAST);
  assign round_next = round_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    q_num_d     = q_num_q;
    time_left_d = time_left_q;
    score_d     = score_q;
    miss_d      = miss_q;
    round_d     = round_q;
    sec_d       = sec_q;
    tick_cnt_d  = '0;

    case (state_q)
      S_IDLE: begin
        if (btn_rise) begin
          score_d = 4'd0;
          miss_d  = 4'd0;
          round_d = 4'd0;
          state_d = S_ARM;
        end
      end
      S_ARM: state_d = S_WAIT_OK;
      S_WAIT_OK: begin
        if (OK) begin
          q_num_d     = NUM;
          time_left_d = ANSWER_SEC_4;
          state_d     = S_ANSWER;
        end
      end
      S_ANSWER: begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        // An answer arriving on a tick cycle takes priority over the countdown.
        if (ANS_VALID) begin
          tick_cnt_d = '0;
          sec_d      = 4'd0;
          if (ANS_CORRECT) begin
            score_d = score_q + 4'd1;
            state_d = S_GOOD;
          end else begin
            miss_d  = miss_q + 4'd1;
            state_d = S_OUCH;
          end
        end else if (tick) begin
          if (time_left_q == 4'd1) begin
            time_left_d = 4'd0;
            miss_d      = miss_q + 4'd1;
            sec_d       = 4'd0;
            state_d     = S_OUCH;
          end else begin
            time_left_d = time_left_q - 4'd1;
          end
        end
      end
      S_GOOD, S_OUCH: begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        if (tick) begin
          if (sec_q == RESULT_LAST) begin
            round_d = round_next;
            if (round_next == ROUNDS_4) begin
              if (score_q > miss_q)      state_d = S_WIN;
              else if (score_q < miss_q) state_d = S_LOSE;
              else                       state_d = S_DRAW;
            end else begin
              state_d = S_ARM;
            end
          end else begin
            sec_d = sec_q + 4'd1;
          end
        end
      end
      S_WIN, S_LOSE, S_DRAW: begin
        if (btn_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_ARM);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      q_num_q     <= 4'd0;
      time_left_q <= 4'd0;
      score_q     <= 4'd0;
      miss_q      <= 4'd0;
      round_q     <= 4'd0;
      sec_q       <= 4'd0;
      tick_cnt_q  <= '0;
      btn_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      q_num_q     <= q_num_d;
      time_left_q <= time_left_d;
      score_q     <= score_d;
      miss_q      <= miss_d;
      round_q     <= round_d;
      sec_q       <= sec_d;
      tick_cnt_q  <= tick_cnt_d;
      btn_q       <= BTN_1P;
    end
  end

  assign STATE     = state_q;
  assign READY_1P  = ready_q;
  assign Q_NUM     = q_num_q;
  assign TIME_LEFT = time_left_q;
  assign SCORE     = score_q;
  assign MISS      = miss_q;
  assign ROUND     = round_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: scripted driver pushes timestamped output snapshots,
// a monitor compares each observed output change against the queue front.
module tb_game_ctrl;

  localparam int W = 25;

  logic       CLK;
  logic       RST;
  logic       BTN_1P;
  logic       OK;
  logic [3:0] NUM;
  logic       ANS_VALID;
  logic       ANS_CORRECT;
  logic [3:0] STATE;
  logic       READY_1P;
  logic [3:0] Q_NUM;
  logic [3:0] TIME_LEFT;
  logic [3:0] SCORE;
  logic [3:0] MISS;
  logic [3:0] ROUND;

  game_ctrl #(
    .SEC_CYCLES(4),
    .ANSWER_SEC(3),
    .RESULT_SEC(2),
    .ROUNDS    (2)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BTN_1P     (BTN_1P),
    .OK         (OK),
    .NUM        (NUM),
    .ANS_VALID  (ANS_VALID),
    .ANS_CORRECT(ANS_CORRECT),
    .STATE      (STATE),
    .READY_1P   (READY_1P),
    .Q_NUM      (Q_NUM),
    .TIME_LEFT  (TIME_LEFT),
    .SCORE      (SCORE),
    .MISS       (MISS),
    .ROUND      (ROUND)
  );

  // clock / cycle counter
  int cyc = 0;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic ex(input int c, input logic [3:0] st, input logic rdy,
                    input logic [3:0] q, input logic [3:0] tl, input logic [3:0] sc,
                    input logic [3:0] ms, input logic [3:0] rd);
    exp_q.push_back({st, rdy, q, tl, sc, ms, rd});
    exp_cyc_q.push_back(c);
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // monitor: every change of the output vector is one DUT event
  initial begin
    logic [W-1:0] cur;
    logic [W-1:0] prev;
    logic [W-1:0] e;
    int           c;
    bit           first;
    first = 1'b1;
    prev  = '0;
    forever begin
      @(negedge CLK);
      cur = {STATE, READY_1P, Q_NUM, TIME_LEFT, SCORE, MISS, ROUND};
      if (first || (cur != prev)) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          if ((e != cur) || (c != cyc)) begin
            n_fail++;
            $display("FAIL out_event cyc=%0d got=%h (state %0d) expected=%h (state %0d) at cyc=%0d",
                     cyc, cur, cur[24:21], e, e[24:21], c);
          end
        end
      end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
        n_checks++;
        n_fail++;
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        $display("FAIL missing_event cyc=%0d got=%h expected=%h at cyc=%0d", cyc, cur, e, c);
      end
      first = 1'b0;
      prev  = cur;
    end
  end

  // driver
  initial begin
    int n;
    RST = 1'b1; BTN_1P = 1'b0; OK = 1'b0; NUM = 4'd0;
    ANS_VALID = 1'b0; ANS_CORRECT = 1'b0;
    ex(1, 0, 0, 0, 0, 0, 0, 0);
    #2 RST = 1'b0;
    step(3);
    RST = 1'b1;
    step(1);

    // start with button held high: one ARM pulse, then parked in WAIT_OK
    n = cyc; BTN_1P = 1'b1;
    ex(n + 1, 1, 1, 0, 0, 0, 0, 0);
    ex(n + 2, 2, 0, 0, 0, 0, 0, 0);
    step(6);

    // OK held 10 cycles; correct answer two cycles into ANSWER
    n = cyc; OK = 1'b1; NUM = 4'd7;
    ex(n + 1, 4, 0, 7, 3, 0, 0, 0);
    step(3);
    ANS_VALID = 1'b1; ANS_CORRECT = 1'b1;
    ex(n + 4,  8, 0, 7, 3, 1, 0, 0);
    ex(n + 12, 1, 1, 7, 3, 1, 0, 1);
    ex(n + 13, 2, 0, 7, 3, 1, 0, 1);
    step(1);
    ANS_VALID = 1'b0; ANS_CORRECT = 1'b0;
    step(6);
    OK = 1'b0; NUM = 4'd0; BTN_1P = 1'b0;
    step(5);

    // timeout round, ends the game in DRAW
    n = cyc; OK = 1'b1; NUM = 4'd5;
    ex(n + 1,  4, 0, 5, 3, 1, 0, 1);
    ex(n + 5,  4, 0, 5, 2, 1, 0, 1);
    ex(n + 9,  4, 0, 5, 1, 1, 0, 1);
    ex(n + 13, 9, 0, 5, 0, 1, 1, 1);
    ex(n + 21, 6, 0, 5, 0, 1, 1, 2);
    step(1);
    OK = 1'b0;
    step(25);
    n = cyc; BTN_1P = 1'b1;
    ex(n + 1, 0, 0, 5, 0, 1, 1, 2);
    step(1);
    BTN_1P = 1'b0;
    step(2);

    // game 3: wrong answer on the final tick, then another wrong -> LOSE
    n = cyc; BTN_1P = 1'b1;
    ex(n + 1, 1, 1, 5, 0, 0, 0, 0);
    ex(n + 2, 2, 0, 5, 0, 0, 0, 0);
    step(1);
    BTN_1P = 1'b0;
    step(2);
    n = cyc; OK = 1'b1; NUM = 4'd9;
    ex(n + 1, 4, 0, 9, 3, 0, 0, 0);
    ex(n + 5, 4, 0, 9, 2, 0, 0, 0);
    ex(n + 9, 4, 0, 9, 1, 0, 0, 0);
    step(1);
    OK = 1'b0;
    step(11);
    ANS_VALID = 1'b1; ANS_CORRECT = 1'b0;
    ex(n + 13, 9, 0, 9, 1, 0, 1, 0);
    ex(n + 21, 1, 1, 9, 1, 0, 1, 1);
    ex(n + 22, 2, 0, 9, 1, 0, 1, 1);
    step(1);
    ANS_VALID = 1'b0;
    step(12);
    n = cyc; OK = 1'b1; NUM = 4'd2;
    ex(n + 1, 4, 0, 2, 3, 0, 1, 1);
    step(1);
    OK = 1'b0; ANS_VALID = 1'b1; ANS_CORRECT = 1'b0;
    ex(n + 2,  9,  0, 2, 3, 0, 2, 1);
    ex(n + 10, 11, 0, 2, 3, 0, 2, 2);
    step(1);
    ANS_VALID = 1'b0;
    step(12);
    n = cyc; BTN_1P = 1'b1;
    ex(n + 1, 0, 0, 2, 3, 0, 2, 2);
    step(1);
    BTN_1P = 1'b0;
    step(1);

    // game 4: two correct answers -> WIN
    n = cyc; BTN_1P = 1'b1;
    ex(n + 1, 1, 1, 2, 3, 0, 0, 0);
    ex(n + 2, 2, 0, 2, 3, 0, 0, 0);
    step(1);
    BTN_1P = 1'b0;
    step(2);
    n = cyc; OK = 1'b1; NUM = 4'd4;
    ex(n + 1, 4, 0, 4, 3, 0, 0, 0);
    step(1);
    OK = 1'b0; ANS_VALID = 1'b1; ANS_CORRECT = 1'b1;
    ex(n + 2,  8, 0, 4, 3, 1, 0, 0);
    ex(n + 10, 1, 1, 4, 3, 1, 0, 1);
    ex(n + 11, 2, 0, 4, 3, 1, 0, 1);
    step(1);
    ANS_VALID = 1'b0; ANS_CORRECT = 1'b0;
    step(12);
    n = cyc; OK = 1'b1; NUM = 4'd11;
    ex(n + 1, 4, 0, 11, 3, 1, 0, 1);
    step(1);
    OK = 1'b0; ANS_VALID = 1'b1; ANS_CORRECT = 1'b1;
    ex(n + 2,  8,  0, 11, 3, 2, 0, 1);
    ex(n + 10, 10, 0, 11, 3, 2, 0, 2);
    step(1);
    ANS_VALID = 1'b0; ANS_CORRECT = 1'b0;
    step(12);

    // game 5: reset dropped mid-ANSWER with TIME_LEFT=2, no clock edge needed
    n = cyc; BTN_1P = 1'b1;
    ex(n + 1, 0, 0, 11, 3, 2, 0, 2);
    step(1);
    BTN_1P = 1'b0;
    step(1);
    n = cyc; BTN_1P = 1'b1;
    ex(n + 1, 1, 1, 11, 3, 0, 0, 0);
    ex(n + 2, 2, 0, 11, 3, 0, 0, 0);
    step(1);
    BTN_1P = 1'b0;
    step(2);
    n = cyc; OK = 1'b1; NUM = 4'd6;
    ex(n + 1, 4, 0, 6, 3, 0, 0, 0);
    ex(n + 5, 4, 0, 6, 2, 0, 0, 0);
    step(1);
    OK = 1'b0;
    step(5);
    RST = 1'b0;
    ex(n + 6, 0, 0, 0, 0, 0, 0, 0);
    step(2);
    RST = 1'b1;
    step(4);

    // report
    while (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL never_seen expected=%h at cyc=%0d", exp_q.pop_front(), exp_cyc_q.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
